pixel_stream_proc: RTL and testbench
====================================

# pixel_stream_proc

Parametrised per-pixel processing engine between the UART receive FIFO and the UART transmit FIFO. It pops one pixel byte from the RX FIFO and applies a run-time-selectable point operation: pass, saturating offset, invert or threshold. It pushes the result into the TX FIFO and counts pixels per frame. A button tick pauses and resumes the stream between pixels, and a frame-done pulse marks the end of each frame.

## Interface
Parameters:
- DATA_W, 8: pixel width in bits; must match the UART FIFO word width.
- FRAME_PIXELS, 64: pixels per frame, ≥2.
- CNT_W, $clog2(FRAME_PIXELS): pixel counter width.

Ports:
- clk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-low reset.
- rx_empty  in  1  RX FIFO empty.
- r_data  in  DATA_W  RX FIFO head word; valid whenever rx_empty=0.
- rd_uart  out  1  RX FIFO pop; one-cycle pulse.
- tx_full  in  1  TX FIFO full.
- w_data  out  DATA_W  word presented to the TX FIFO.
- wr_uart  out  1  TX FIFO push.
- mode  in  2  operation select: 0 pass, 1 add offset, 2 invert, 3 threshold.
- offset  in  DATA_W  unsigned addend for mode 1.
- thresh  in  DATA_W  threshold for mode 3.
- btn_tick  in  1  one-cycle pulse (already debounced); toggles hold.
- hold  out  1  stream paused.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is pushed.
- pix_cnt  out  CNT_W  pixels pushed so far in the current frame.
- led  out  DATA_W  last pushed result.

## Operation
The FSM has four states: IDLE, CAP, PROC, WRITE.
- IDLE: when rx_empty=0 and hold=0, go to CAP.
- CAP: rd_uart=1 for this cycle only; din <= r_data; go to PROC.
- PROC: dout <= f(din, cfg); go to WRITE.
- WRITE: wr_uart = !tx_full (combinational from state and tx_full); w_data = dout throughout WRITE.
  - On the cycle the push happens: led <= dout, the pixel counter advances, and the FSM returns to IDLE.
  - While tx_full=1 the FSM stays in WRITE and dout stays stable.

Configuration latch:
- cfg = {mode, offset, thresh} is registered when CAP is entered with pix_cnt==0, i.e. at the first pixel of each frame.
- Input changes mid-frame take effect from the next frame.

Operations, all computed in DATA_W bits:
- pass: dout = din.
- offset: the sum is computed in DATA_W+1 bits; if the carry is set, dout = all ones, otherwise the low DATA_W bits. The result never wraps.
- invert: dout = ~din.
- threshold: dout = all ones if din ≥ thresh, else 0.

Pixel counter:
- Increments on every push.
- On the push with pix_cnt==FRAME_PIXELS-1: pix_cnt <= 0 and frame_done=1 for that cycle.

Hold:
- btn_tick toggles hold in any state.
- hold is sampled only in IDLE, so a pixel already in CAP, PROC or WRITE always completes.

## Timing
- Reset values: state=IDLE, rd_uart=0, wr_uart=0, w_data=0, hold=0, busy=0, frame_done=0, pix_cnt=0, led=0, cfg=0 (mode 0).
- Reset mid-operation: an asserted reset forces the reset values immediately (asynchronous). A pixel that was popped but not pushed is dropped; no partial push is issued.
- Latency: rx_empty falls in cycle 0 (FSM in IDLE) → rd_uart=1 in cycle 1 → wr_uart=1 in cycle 3 if tx_full=0.
- Throughput: at most 1 pixel per 4 cycles.
- RX handshake: exactly one rd_uart pulse per pixel; rd_uart is never asserted while rx_empty=1.
- TX handshake: exactly one wr_uart pulse per pixel; wr_uart is never asserted while tx_full=1.
- Timing of busy and frame_done:
  - busy is registered from the state.
  - frame_done coincides with the final wr_uart pulse of the frame.
- btn_tick arriving in the same cycle as the IDLE→CAP decision: the decision uses the old hold value, and the toggle is effective from the next cycle.
- An empty RX FIFO at IDLE leaves the FSM waiting indefinitely with no pulses on rd_uart or wr_uart.

## Test plan
- Pass mode: push 0x00, 0x7F, 0xFF into RX → TX receives 0x00, 0x7F, 0xFF in order. Each rd_uart→wr_uart spacing is 2 cycles; led=0xFF at the end.
- Offset mode, offset=50: inputs 0x10, 0xCD, 0xF0 → outputs 0x42, 0xFF, 0xFF (saturated, no wrap).
- Invert mode, then threshold mode with thresh=0x80:
  - Invert: input 0x0F → 0xF0.
  - Threshold: inputs 0x7F, 0x80 → 0x00, 0xFF.
- Backpressure: hold tx_full=1 for 20 cycles while in WRITE → wr_uart stays 0 and w_data stays stable; exactly one push follows after tx_full falls; no extra pops.
- Frame boundary, FRAME_PIXELS=4:
  - 9 pixels are sent → frame_done pulses on pushes 4 and 8; pix_cnt=1 at the end.
  - mode changes from 0 to 2 at pixel 2 → pixels 2–4 stay pass, and inversion starts at pixel 5.
- Hold and reset:
  - btn_tick in IDLE with data available → no rd_uart until a second btn_tick.
  - reset asserted low while in PROC → all outputs return to their reset values at once; after release the next RX word is processed normally.

Source files
------------

// File: rtl/pixel_stream_proc.sv
// Per-pixel point-operation engine between the UART RX and TX FIFOs.
// Pops a pixel, applies pass/offset/invert/threshold, pushes it and tracks frame position.
module pixel_stream_proc #(
  parameter int DATA_W       = 8,
  parameter int FRAME_PIXELS = 64,
  parameter int CNT_W        = $clog2(FRAME_PIXELS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] r_data,
  output logic              rd_uart,
  input  logic              tx_full,
  output logic [DATA_W-1:0] w_data,
  output logic              wr_uart,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] offset,
  input  logic [DATA_W-1:0] thresh,
  input  logic              btn_tick,
  output logic              hold,
  output logic              busy,
  output logic              frame_done,
  output logic [CNT_W-1:0]  pix_cnt,
  output logic [DATA_W-1:0] led
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAP   = 2'd1,
    PROC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIXELS - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   led_q, led_d;
  logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d;
  logic                hold_q, hold_d;
  logic                busy_q, busy_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   offset_q, offset_d;
  logic [DATA_W-1:0]   thresh_q, thresh_d;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   op_result;

  // Point operation on the captured pixel using the frame's latched configuration.
  always_comb begin
    sum       = {1'b0, din_q} + {1'b0, offset_q};
    op_result = din_q;
    case (mode_q)
      2'd0: op_result = din_q;
      2'd1: op_result = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      2'd2: op_result = ~din_q;
      2'd3: op_result = (din_q >= thresh_q) ? '1 : '0;
      default: op_result = din_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    dout_d     = dout_q;
    led_d      = led_q;
    pix_cnt_d  = pix_cnt_q;
    mode_d     = mode_q;
    offset_d   = offset_q;
    thresh_d   = thresh_q;
    hold_d     = hold_q ^ btn_tick;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        // Old hold value gates the decision; a same-cycle btn_tick only affects later cycles.
        if (!rx_empty && !hold_q) begin
          state_d = CAP;
          if (pix_cnt_q == '0) begin
            mode_d   = mode;
            offset_d = offset;
            thresh_d = thresh;
          end
        end
      end
      CAP: begin
        rd_uart = 1'b1;
        din_d   = r_data;
        state_d = PROC;
      end
      PROC: begin
        dout_d  = op_result;
        state_d = WRITE;
      end
      WRITE: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          led_d   = dout_q;
          state_d = IDLE;
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d  = '0;
            frame_done = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      din_q     <= '0;
      dout_q    <= '0;
      led_q     <= '0;
      pix_cnt_q <= '0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= '0;
      offset_q  <= '0;
      thresh_q  <= '0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      led_q     <= led_d;
      pix_cnt_q <= pix_cnt_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      offset_q  <= offset_d;
      thresh_q  <= thresh_d;
    end
  end

  assign w_data  = dout_q;
  assign hold    = hold_q;
  assign busy    = busy_q;
  assign pix_cnt = pix_cnt_q;
  assign led     = led_q;

endmodule

// File: tb/tb_pixel_stream_proc.sv
// Bench for pixel_stream_proc: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_pixel_stream_proc;

  localparam int FP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       tx_full = 1'b0;
  logic [7:0] w_data;
  logic       wr_uart;
  logic [1:0] mode = 2'd0;
  logic [7:0] offset = 8'd0;
  logic [7:0] thresh = 8'd0;
  logic       btn_tick = 1'b0;
  logic       hold;
  logic       busy;
  logic       frame_done;
  logic [1:0] pix_cnt;
  logic [7:0] led;

  pixel_stream_proc #(.DATA_W(8), .FRAME_PIXELS(FP)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .mode(mode), .offset(offset),
    .thresh(thresh), .btn_tick(btn_tick), .hold(hold), .busy(busy), .frame_done(frame_done),
    .pix_cnt(pix_cnt), .led(led)
  );

  always #5 clk = ~clk;

  // RX FIFO stand-in: stimulus appends at wr_ptr, DUT pops advance rd_ptr.
  logic [7:0] mem [0:4095];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign rx_empty = (rd_ptr == wr_ptr);
  assign r_data   = mem[rd_ptr[11:0]];
  always @(posedge clk) if (rd_uart) rd_ptr <= rd_ptr + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state (describes the most recently evaluated cycle).
  int         m_ptr = 0, count = 0, age = 0;
  logic       busy_m = 0, push_m = 0, hold_m = 0, rst_m = 1, btn_p = 0, empty_p = 1;
  logic [7:0] exp_val = 0, led_m = 0;
  logic [1:0] mode_p = 0, mode_c = 0;
  logic [7:0] off_p = 0, th_p = 0, off_c = 0, th_c = 0;
  logic [7:0] out_log [$];
  int         fd_idx [$];

  function automatic logic [7:0] ref_op(input logic [1:0] m, input logic [7:0] d,
                                        input logic [7:0] off, input logic [7:0] th);
    int s;
    s = int'(d) + int'(off);
    case (m)
      2'd0:    return d;
      2'd1:    return (s > 255) ? 8'hFF : 8'(s);
      2'd2:    return 8'(255 - int'(d));
      default: return (d >= th) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic exp_rd, exp_push, cur_busy, hold_now, empty_now;
    @(negedge clk);
    empty_now = (m_ptr == wr_ptr);
    if (!reset) begin
      chk("rst_rd_uart", rd_uart, 0);
      chk("rst_wr_uart", wr_uart, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_hold", hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_pix_cnt", pix_cnt, 0);
      chk("rst_led", led, 0);
      busy_m = 0; push_m = 0; hold_m = 0; rst_m = 1; count = 0; led_m = 0;
    end else begin
      hold_now = rst_m ? 1'b0 : (hold_m ^ btn_p);
      exp_rd   = !rst_m && !busy_m && !hold_m && !empty_p;
      cur_busy = exp_rd || (busy_m && !push_m);
      if (exp_rd) begin
        if (count == 0) begin
          mode_c = mode_p; off_c = off_p; th_c = th_p;
        end
        exp_val = ref_op(mode_c, mem[m_ptr[11:0]], off_c, th_c);
        m_ptr++;
        age = 0;
      end else begin
        age++;
      end
      exp_push = cur_busy && (age >= 2) && !tx_full;
      chk("rd_uart", rd_uart, exp_rd);
      chk("wr_uart", wr_uart, exp_push);
      chk("busy", busy, cur_busy);
      chk("hold", hold, hold_now);
      chk("pix_cnt", pix_cnt, count);
      chk("led", led, led_m);
      chk("frame_done", frame_done, exp_push && (count == FP - 1));
      if (cur_busy && age >= 2) chk("w_data", w_data, exp_val);
      if (wr_uart) begin
        out_log.push_back(w_data);
        if (frame_done) fd_idx.push_back(out_log.size());
      end
      if (exp_push) begin
        led_m = exp_val;
        count = (count == FP - 1) ? 0 : count + 1;
      end
      busy_m = cur_busy; push_m = exp_push; hold_m = hold_now; rst_m = 0;
    end
    btn_p = btn_tick; empty_p = empty_now;
    mode_p = mode; off_p = offset; th_p = thresh;
    @(posedge clk);
    #1;
    btn_tick = 1'b0;
  endtask

  task automatic send(input logic [7:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    out_log.delete();
    fd_idx.delete();
  endtask

  task automatic wait_pushes(input int n, input int budget);
    int k = 0;
    while (out_log.size() < n && k < budget) begin
      step();
      k++;
    end
    chk("push_count", out_log.size(), n);
  endtask

  initial begin
    logic [7:0] p;
    int k;
    repeat (3) step();
    reset = 1'b1;
    step();

    // Pass mode
    mode = 2'd0;
    send(8'h00); send(8'h7F); send(8'hFF);
    wait_pushes(3, 40);
    chk("pass0", out_log[0], 8'h00);
    chk("pass1", out_log[1], 8'h7F);
    chk("pass2", out_log[2], 8'hFF);
    step();
    chk("pass_led", led, 8'hFF);

    // Saturating offset
    do_reset();
    mode = 2'd1; offset = 8'd50;
    send(8'h10); send(8'hCD); send(8'hF0);
    wait_pushes(3, 40);
    chk("off0", out_log[0], 8'h42);
    chk("off1", out_log[1], 8'hFF);
    chk("off2", out_log[2], 8'hFF);

    // Invert, then threshold in a fresh frame
    do_reset();
    mode = 2'd2;
    send(8'h0F);
    wait_pushes(1, 20);
    chk("inv0", out_log[0], 8'hF0);
    do_reset();
    mode = 2'd3; thresh = 8'h80;
    send(8'h7F); send(8'h80);
    wait_pushes(2, 30);
    chk("thr0", out_log[0], 8'h00);
    chk("thr1", out_log[1], 8'hFF);

    // Backpressure: 20 cycles stuck in WRITE
    do_reset();
    mode = 2'd0; tx_full = 1'b1;
    send(8'hAA);
    repeat (23) step();
    chk("bp_no_push", out_log.size(), 0);
    tx_full = 1'b0;
    wait_pushes(1, 5);
    repeat (6) step();
    chk("bp_one_push", out_log.size(), 1);
    chk("bp_data", out_log[0], 8'hAA);
    chk("bp_no_extra_pop", rd_ptr, wr_ptr);

    // Frame boundary with mid-frame mode change
    do_reset();
    mode = 2'd0;
    send(8'h13);
    wait_pushes(1, 20);
    mode = 2'd2;
    for (int i = 2; i <= 9; i++) send(8'(16 * i + 3));
    wait_pushes(9, 80);
    for (int i = 1; i <= 9; i++) begin
      p = 8'(16 * i + 3);
      chk($sformatf("frame_px%0d", i), out_log[i-1], (i <= 4) ? p : 8'(255 - int'(p)));
    end
    chk("fd_pulses", fd_idx.size(), 2);
    if (fd_idx.size() == 2) begin
      chk("fd_first", fd_idx[0], 4);
      chk("fd_second", fd_idx[1], 8);
    end
    step();
    chk("frame_cnt_end", pix_cnt, 1);

    // Hold via button
    do_reset();
    mode = 2'd0;
    btn_tick = 1'b1;
    step();
    send(8'h55);
    repeat (12) step();
    chk("hold_blocks", out_log.size(), 0);
    btn_tick = 1'b1;
    step();
    wait_pushes(1, 20);
    chk("hold_resume", out_log[0], 8'h55);

    // Asynchronous reset while in PROC
    do_reset();
    send(8'h33);
    k = 0;
    while (!(busy_m && age == 0) && k < 20) begin step(); k++; end
    chk("reach_cap", busy_m && age == 0, 1);
    reset = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_w_data", w_data, 0);
    chk("async_wr_uart", wr_uart, 0);
    step();
    reset = 1'b1;
    step();
    chk("rst_dropped", out_log.size(), 0);
    send(8'h77);
    wait_pushes(1, 20);
    chk("post_rst_data", out_log[0], 8'h77);

    // Randomized soak
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(5) == 0 && (wr_ptr - m_ptr) < 8) send(8'($urandom));
      tx_full = ($urandom_range(3) == 0);
      if ($urandom_range(60) == 0) btn_tick = 1'b1;
      if ($urandom_range(30) == 0) begin
        mode = 2'($urandom); offset = 8'($urandom); thresh = 8'($urandom);
      end
      step();
    end
    tx_full = 1'b0;
    if (hold_m) begin
      btn_tick = 1'b1;
      step();
    end
    k = 0;
    while ((m_ptr != wr_ptr || busy_m) && k < 300) begin step(); k++; end
    chk("drain_done", (m_ptr == wr_ptr) && !busy_m, 1);
    repeat (3) step();
    chk("drain_fifo", rd_ptr, wr_ptr);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
